// File: rtl/fetch_unit.sv
// Fetch unit: holds the PC, fetches instruction words over a req/ready
// handshake, latches them into the instruction register and decodes the
// fixed fields for the control unit and register file.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            instr_ack,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7_5,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            misalign,
  output logic [31:0]     fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              r_imem_req;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_fetch_count;

  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_next_pc;
  logic              w_accept;

  // Sequential next-PC selection; pc_target is used verbatim.
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_next_pc  = pc_src ? pc_target : w_pc_plus4;
  assign w_accept   = !stall && instr_ack;

  // Fetch FSM with registered request, instruction and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
            r_instr_valid <= 1'b0;
            if (w_next_pc[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= TRAP;
            end else begin
              r_pc       <= w_next_pc;
              r_imem_req <= 1'b1;
              r_state    <= REQ;
            end
          end
        end
        TRAP: begin
          r_state <= TRAP;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output wiring and field decode of the instruction register.
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign misalign    = r_misalign;
  assign fetch_count = r_fetch_count;
  assign op          = r_instr[6:0];
  assign rd          = r_instr[11:7];
  assign funct3      = r_instr[14:12];
  assign rs1         = r_instr[19:15];
  assign rs2         = r_instr[24:20];
  assign funct7_5    = r_instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        misalign;
  logic [31:0] fetch_count;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_ack  (instr_ack),
    .stall      (stall),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .misalign   (misalign),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch unit should present to the outside.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_req;
  logic        m_mis;
  logic [31:0] m_cnt;
  bit          m_boot;
  bit          m_trap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] np;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0; m_req = 1'b0;
      m_mis = 1'b0; m_cnt = 32'h0; m_boot = 1'b1; m_trap = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_trap) begin
      // trapped: nothing moves until reset
    end else if (m_req) begin
      if (imem_ready) begin
        m_instr = imem_rdata;
        m_valid = 1'b1;
        m_req   = 1'b0;
      end
    end else if (m_valid && !stall && instr_ack) begin
      m_cnt   = m_cnt + 32'd1;
      m_valid = 1'b0;
      np      = pc_src ? pc_target : m_pc + 32'd4;
      if (np % 4 != 0) begin
        m_mis  = 1'b1;
        m_trap = 1'b1;
      end else begin
        m_pc  = np;
        m_req = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] fields_got;
    logic [31:0] fields_exp;
    check_eq("imem_req", 32'(imem_req), 32'(m_req));
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
    check_eq("instr", instr, m_instr);
    check_eq("misalign", 32'(misalign), 32'(m_mis));
    check_eq("fetch_count", fetch_count, m_cnt);
    fields_got = {4'h0, op, funct3, 1'b0, funct7_5, rs1, rs2, rd};
    fields_exp = {4'h0, 7'((m_instr) % 128), 3'((m_instr / 4096) % 8), 1'b0,
                  1'((m_instr / 32'h4000_0000) % 2), 5'((m_instr / 32768) % 32),
                  5'((m_instr / 32'h0010_0000) % 32), 5'((m_instr / 128) % 32)};
    check_eq("fields", fields_got, fields_exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic rdy, input logic ack, input logic stl,
                        input logic src, input logic [31:0] tgt);
    imem_ready = rdy; instr_ack = ack; stall = stl; pc_src = src; pc_target = tgt;
  endtask

  logic [31:0] addrs [$];

  initial begin
    reset = 1'b1;
    imem_rdata = 32'h0000_0000;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    m_boot = 1'b0; m_trap = 1'b0;
    @(negedge clk);
    step();
    check_eq("rst_req", 32'(imem_req), 32'h0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_count", fetch_count, 32'h0);

    // Zero-wait memory, immediate ack: one new address every 2 cycles.
    reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      imem_rdata = 32'h0000_0013 + 32'(i) * 32'h100;
      step();
      if (i == 0) check_eq("first_req", 32'(imem_req), 32'h1);
      if (imem_req) addrs.push_back(imem_addr);
    end
    for (int i = 0; i < 4; i++) check_eq("seq_addr", addrs[i], 32'(i) * 32'd4);
    check_eq("seq_count", fetch_count, 32'd4);

    // Slow memory: request held with a stable address, then add decoded.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    imem_rdata = 32'h00A3_0333;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wait_req", 32'(imem_req), 32'h1);
      check_eq("wait_addr", imem_addr, 32'h10);
    end
    imem_ready = 1'b1;
    step();
    check_eq("add_valid", 32'(instr_valid), 32'h1);
    check_eq("add_op", 32'(op), 32'h33);
    check_eq("add_rd", 32'(rd), 32'd6);
    check_eq("add_rs1", 32'(rs1), 32'd6);
    check_eq("add_rs2", 32'(rs2), 32'd10);
    check_eq("add_f3", 32'(funct3), 32'd0);
    check_eq("add_f7", 32'(funct7_5), 32'd0);

    // Stall overrides ack for 5 cycles.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_pc", pc, 32'h10);
      check_eq("stall_valid", 32'(instr_valid), 32'h1);
      check_eq("stall_count", fetch_count, 32'd4);
    end
    stall = 1'b0;
    step();
    check_eq("redir_addr", imem_addr, 32'h100);
    check_eq("redir_count", fetch_count, 32'd5);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    instr_ack = 1'b1;
    step();
    check_eq("seq_after_redir", imem_addr, 32'h104);

    // PC wrap: redirect to the top word, then +4 wraps to 0 with no flag.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    step();
    check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
    pc_src = 1'b0;
    step();
    step();
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_mis", 32'(misalign), 32'h0);

    // Reset while a request is outstanding.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    step();
    check_eq("midrst_req", 32'(imem_req), 32'h0);
    check_eq("midrst_instr", instr, 32'h0000_0013);

    // Misaligned redirect traps until reset.
    reset = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    step();
    step();
    instr_ack = 1'b1;
    step();
    check_eq("trap_mis", 32'(misalign), 32'h1);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, 1'(i % 2), 1'b0, $urandom);
      step();
      check_eq("trap_req", 32'(imem_req), 32'h0);
    end
    reset = 1'b1;
    step();
    check_eq("trap_clr_mis", 32'(misalign), 32'h0);
    check_eq("trap_clr_pc", pc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      imem_ready = 1'($urandom_range(0, 1));
      instr_ack  = 1'($urandom_range(0, 1));
      stall      = ($urandom_range(0, 3) == 0);
      pc_src     = ($urandom_range(0, 9) < 3);
      pc_target  = $urandom;
      if ($urandom_range(0, 19) != 0) pc_target[1:0] = 2'b00;
      imem_rdata = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
